// File: rtl/uart_rx_word.sv
// uart_rx_word: 8N1 UART receiver with 16x oversampling and a 3-sample majority vote.
// Each received byte is held in a 16-bit status/data word until the consumer pulses clear:
//   out[15]=ready, out[10]=parity_err, out[9]=overrun, out[8]=frame_err, out[7:0]=data.
// Optional feature macro: UART_RX_PARITY_EN adds an even-parity bit after the data bits
// (11-bit frame). Without it the frame is 10 bits and out[10] stays 0.
// Handshake: clear is a single-cycle strobe. It acknowledges the held word only while
// ready is 1. A commit in the same cycle takes priority over clear.
module uart_rx_word #(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 115200,
    parameter int OVERSAMPLE = 16
) (
    input  logic        CLK_100MHz,
    input  logic        rst_n,
    input  logic        RX,
    input  logic        clear,
    output logic [15:0] out,
    output logic        rx_ready,
    output logic        rx_busy
);

    localparam int DIV   = CLK_HZ / (BAUD * OVERSAMPLE);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rxs_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       idx_q, idx_d;
    logic             s7_q, s8_q;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             armed_q, armed_d;
    logic             ready_q, ovr_q, ferr_q, perr_q;
    logic [7:0]       data_q;
    logic             tick, mid, vote, commit;
`ifdef UART_RX_PARITY_EN
    logic             par_q, par_d;
`endif

    // A tick marks the end of one oversample period; the vote point is the tick at index 9.
    assign tick = (state_q != S_IDLE) && (div_q == DIV_LAST);
    assign mid  = tick && (idx_q == 4'd9);
    assign vote = (s7_q & s8_q) | (s7_q & rxs_q) | (s8_q & rxs_q);

    // Two-flop synchroniser, both flops reset to the idle-high line level.
    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
        end
    end

    // Capture the synchronised line at tick indices 7 and 8; index 9 is used live in the vote.
    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            s7_q <= 1'b1;
            s8_q <= 1'b1;
        end else begin
            if (tick && idx_q == 4'd7) s7_q <= rxs_q;
            if (tick && idx_q == 4'd8) s8_q <= rxs_q;
        end
    end

    // Tick divider and per-bit tick index; both sit at zero in IDLE so a frame aligns to its start edge.
    always_comb begin
        div_d = div_q;
        idx_d = idx_q;
        if (state_q == S_IDLE) begin
            div_d = '0;
            idx_d = 4'd0;
        end else begin
            div_d = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
            if (tick) idx_d = idx_q + 4'd1;
        end
    end

    // Next-state logic: start detection, bit shifting and the commit strobe.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        commit    = 1'b0;
        // Start detection is armed only after the line has been seen high, so a held-low
        // line (break) cannot retrigger a frame.
        armed_d   = rxs_q ? 1'b1 : armed_q;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (!rxs_q && armed_q) state_d = S_START;
            end
            S_START: begin
                if (mid) begin
                    if (vote) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d   = S_DATA;
                        bit_cnt_d = 3'd0;
                    end
                end
            end
            S_DATA: begin
                if (mid) begin
                    shift_d   = {vote, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (mid) begin
                    par_d   = vote;
                    state_d = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (mid) begin
                    commit  = 1'b1;
                    state_d = S_IDLE;
                    if (!vote) armed_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receive-path state registers.
    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            idx_q     <= 4'd0;
            bit_cnt_q <= 3'd0;
            shift_q   <= 8'h00;
            armed_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            idx_q     <= idx_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            armed_q   <= armed_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    // Parity vote register and even-parity check flag.
    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            par_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            par_q <= par_d;
            if (commit)                perr_q <= (^shift_q) ^ par_q;
            else if (clear && ready_q) perr_q <= 1'b0;
        end
    end
`else
    assign perr_q = 1'b0;
`endif

    // Held status/data word: commit loads a new frame, clear acknowledges it; commit wins.
    always_ff @(posedge CLK_100MHz or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
            data_q  <= 8'h00;
        end else if (commit) begin
            data_q  <= shift_q;
            ready_q <= 1'b1;
            ferr_q  <= ~vote;
            if (clear)        ovr_q <= 1'b0;
            else if (ready_q) ovr_q <= 1'b1;
        end else if (clear && ready_q) begin
            ready_q <= 1'b0;
            ovr_q   <= 1'b0;
            ferr_q  <= 1'b0;
        end
    end

    assign out      = {ready_q, 4'b0000, perr_q, ovr_q, ferr_q, data_q};
    assign rx_ready = ready_q;
    assign rx_busy  = (state_q != S_IDLE);

endmodule
